// File: rtl/cmp_window_monitor.sv
// Purpose: windowed statistics for comparator samples (lt/eq/gt/err counts, max operand, sample count).
// Latency: the summary is valid the cycle after the closing sample or flush; one bubble cycle minimum between windows.
// Backpressure: in_ready is low while a summary waits; out_ready low holds the summary indefinitely.
// Optional: define CMP_SELFCHECK_EN to check l/e/g against the a/b comparison.
module cmp_window_monitor #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             l,
    input  logic             e,
    input  logic             g,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] lt_count,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       max_val,
    output logic [7:0]       sample_count
);

    typedef enum logic {ACCUM = 1'b0, REPORT = 1'b1} state_t;

    localparam logic [7:0] WIN8 = 8'(WINDOW);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] lt_q, lt_d, eq_q, eq_d, gt_q, gt_d, err_q, err_d;
    logic [7:0]       max_q, max_d, cnt_q, cnt_d;
    logic [7:0]       cnt_inc;
    logic             accept, sample_ok, close_win, hs;

    assign accept  = in_valid && (state_q == ACCUM);
    assign hs      = (state_q == REPORT) && out_ready;
    assign cnt_inc = cnt_q + 8'd1;

    // A sample counts towards a category only if its flags are a valid one-hot outcome.
`ifdef CMP_SELFCHECK_EN
    always_comb begin
        sample_ok = ({l, e, g} == {(a < b), (a == b), (a > b)});
    end
`else
    always_comb begin
        sample_ok = 1'b0;
        case ({l, e, g})
            3'b100, 3'b010, 3'b001: sample_ok = 1'b1;
            default:                sample_ok = 1'b0;
        endcase
    end
`endif

    // Window closes on the WINDOW-th sample, or on flush when the window holds (or is receiving) data.
    always_comb begin
        close_win = 1'b0;
        if (state_q == ACCUM) begin
            close_win = (accept && (cnt_inc == WIN8)) ||
                        (flush && (accept || (cnt_q != 8'd0)));
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ACCUM;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (close_win) state_d = REPORT;
            REPORT:  if (out_ready) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == REPORT);
    end

    // Next values of the statistics: cleared on summary handshake, updated on accept, saturating.
    always_comb begin
        lt_d  = lt_q;
        eq_d  = eq_q;
        gt_d  = gt_q;
        err_d = err_q;
        max_d = max_q;
        cnt_d = cnt_q;
        if (hs) begin
            lt_d  = '0;
            eq_d  = '0;
            gt_d  = '0;
            err_d = '0;
            max_d = 8'd0;
            cnt_d = 8'd0;
        end else if (accept) begin
            if (!sample_ok) begin
                if (err_q != '1) err_d = err_q + 1'b1;
            end else if (l) begin
                if (lt_q != '1) lt_d = lt_q + 1'b1;
            end else if (e) begin
                if (eq_q != '1) eq_d = eq_q + 1'b1;
            end else begin
                if (gt_q != '1) gt_d = gt_q + 1'b1;
            end
            if (a > max_d) max_d = a;
            if (b > max_d) max_d = b;
            if (cnt_q != 8'hFF) cnt_d = cnt_inc;
        end
    end

    // Statistics registers; reset discards the window immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt_q  <= '0;
            eq_q  <= '0;
            gt_q  <= '0;
            err_q <= '0;
            max_q <= 8'd0;
            cnt_q <= 8'd0;
        end else begin
            lt_q  <= lt_d;
            eq_q  <= eq_d;
            gt_q  <= gt_d;
            err_q <= err_d;
            max_q <= max_d;
            cnt_q <= cnt_d;
        end
    end

    assign lt_count     = lt_q;
    assign eq_count     = eq_q;
    assign gt_count     = gt_q;
    assign err_count    = err_q;
    assign max_val      = max_q;
    assign sample_count = cnt_q;

endmodule

// File: tb/tb_cmp_window_monitor.sv
// Purpose: scoreboard bench for cmp_window_monitor; summaries are checked on each out handshake.
// Latency: expected summaries are queued when a window is closed by the stimulus.
// Backpressure: out_ready is driven by the stimulus to exercise holding a summary.
module tb_cmp_window_monitor;

    logic       clk, rst_n;
    logic       in_valid, in_ready, l, e, g, flush, out_valid, out_ready;
    logic [7:0] a, b;
    logic [7:0] lt_count, eq_count, gt_count, err_count, max_val, sample_count;

    typedef struct {
        int lt, eq, gt, err, mx, cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    cmp_window_monitor #(.WINDOW(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .l(l), .e(e), .g(g), .a(a), .b(b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .lt_count(lt_count), .eq_count(eq_count), .gt_count(gt_count),
        .err_count(err_count), .max_val(max_val), .sample_count(sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int lt, input int eq, input int gt, input int err,
                        input int mx, input int cnt);
        exp_t x;
        x.lt = lt; x.eq = eq; x.gt = gt; x.err = err; x.mx = mx; x.cnt = cnt;
        exp_q.push_back(x);
    endtask

    // Monitor: compare each presented summary at the moment it is handed off.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_summary", 1, 0);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("sum_lt",  int'(lt_count),     x.lt);
                chk("sum_eq",  int'(eq_count),     x.eq);
                chk("sum_gt",  int'(gt_count),     x.gt);
                chk("sum_err", int'(err_count),    x.err);
                chk("sum_max", int'(max_val),      x.mx);
                chk("sum_cnt", int'(sample_count), x.cnt);
            end
        end
    end

    // Issue one sample; returns 1 time unit after the accepting edge.
    task automatic send(input logic li, input logic ei, input logic gi,
                        input logic [7:0] ai, input logic [7:0] bi);
        int n;
        l = li; e = ei; g = gi; a = ai; b = bi; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; l = 0; e = 0; g = 0; a = 0; b = 0;
        flush = 1'b0; out_ready = 1'b1;
        #3;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_cnt",       int'(sample_count), 0);
        chk("rst_max",       int'(max_val), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Full window of alternating lt / eq samples.
        push(8, 8, 0, 0, 45, 16);
        for (int i = 0; i < 8; i++) begin
            send(1, 0, 0, 8'd10, 8'd20);
            send(0, 1, 0, 8'd45, 8'd45);
        end
        chk("win_out_valid", int'(out_valid), 1);
        chk("win_in_ready",  int'(in_ready), 0);
        @(posedge clk); #1;
        chk("win_cleared_cnt", int'(sample_count), 0);
        chk("win_cleared_eq",  int'(eq_count), 0);
        chk("win_in_ready_back", int'(in_ready), 1);

        // Partial window closed by flush.
        push(0, 0, 3, 0, 200, 3);
        repeat (3) send(0, 0, 1, 8'd200, 8'd7);
        chk("pre_flush_valid", int'(out_valid), 0);
        pulse_flush();
        chk("flush_out_valid", int'(out_valid), 1);
        idle(1);
        pulse_flush();
        chk("empty_flush_valid", int'(out_valid), 0);
        idle(1);
        chk("empty_flush_valid2", int'(out_valid), 0);

        // Malformed flags.
        push(0, 0, 0, 2, 6, 2);
        send(1, 0, 1, 8'd5, 8'd6);
        send(0, 0, 0, 8'd3, 8'd2);
        pulse_flush();
        idle(1);

        // Full window held under out_ready=0 while the producer keeps pushing.
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] av;
            av = 8'(i * 10);
            send(av < 8'd7, av == 8'd7, av > 8'd7, av, 8'd7);
        end
        l = 1; e = 0; g = 0; a = 8'd1; b = 8'd2; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_in_ready",  int'(in_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_lt",  int'(lt_count), 1);
            chk("stall_gt",  int'(gt_count), 15);
            chk("stall_max", int'(max_val), 150);
            chk("stall_cnt", int'(sample_count), 16);
        end
        push(1, 0, 15, 0, 150, 16);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_stall_in_ready", int'(in_ready), 1);
        chk("post_stall_cnt", int'(sample_count), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("new_window_cnt", int'(sample_count), 1);
        chk("new_window_lt",  int'(lt_count), 1);
        push(1, 0, 0, 0, 2, 1);
        pulse_flush();
        idle(1);

        // Asynchronous reset in the middle of a window.
        repeat (5) send(0, 1, 0, 8'd9, 8'd9);
        chk("pre_rst_cnt", int'(sample_count), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", int'(sample_count), 0);
        chk("async_rst_eq",  int'(eq_count), 0);
        chk("async_rst_max", int'(max_val), 0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        push(1, 0, 0, 0, 4, 1);
        send(1, 0, 0, 8'd3, 8'd4);
        chk("after_rst_cnt", int'(sample_count), 1);
        pulse_flush();
        idle(1);

        // Flags that contradict a/b.
`ifdef CMP_SELFCHECK_EN
        push(0, 0, 0, 1, 40, 1);
`else
        push(0, 0, 1, 0, 40, 1);
`endif
        send(0, 0, 1, 8'd30, 8'd40);
        pulse_flush();
        idle(3);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmp_window_monitor.md
Name: cmp_window_monitor

Overview:
- Downstream consumer of the 8-bit magnitude comparator. Each accepted sample is one operand pair a/b plus the comparator's lesser/equal/greater flags.
- Accumulates outcome statistics over a fixed window of samples, then presents a registered summary through a valid/ready handshake.
- Sits between the comparator and the system's reporting/logging logic.

Parameters:
- WINDOW, 16, samples per report window; legal range 1..255.
- CNT_W, 8, width of every outcome counter; counters saturate at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample present on l/e/g/a/b.
- in_ready  output  1  monitor can accept a sample.
- l  input  1  comparator lesser flag (a<b).
- e  input  1  comparator equal flag.
- g  input  1  comparator greater flag.
- a  input  8  operand a.
- b  input  8  operand b.
- flush  input  1  single-cycle request to close a partial window early.
- out_valid  output  1  summary valid.
- out_ready  input  1  consumer accepts the summary.
- lt_count  output  CNT_W  count of lesser samples in the window.
- eq_count  output  CNT_W  count of equal samples.
- gt_count  output  CNT_W  count of greater samples.
- err_count  output  CNT_W  count of malformed samples.
- max_val  output  8  largest a or b value accepted in the window.
- sample_count  output  8  total samples accepted in the window.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; clock port is clk, reset port is rst_n.
- Reset values: state=ACCUM, in_ready=1, out_valid=0; all counters, max_val and sample_count = 0.
- FSM has two states: ACCUM and REPORT.
- ACCUM:
  - in_ready=1.
  - A sample is accepted when in_valid && in_ready at a rising edge.
  - Well-formed sample (exactly one of l/e/g set): increment the matching counter.
  - Malformed sample (zero or more than one flag set): increment err_count only; no category counter changes.
  - max_val <= max(max_val, a, b) on every accepted sample, malformed or not.
  - sample_count increments on every accepted sample.
- Window close, ACCUM->REPORT:
  - Occurs on the edge where the WINDOW-th sample is accepted. That sample is included in the summary.
  - Also occurs on flush=1 in ACCUM with sample_count>0 (after including any sample accepted in the same cycle).
  - flush with sample_count==0 and no sample accepted that cycle is ignored.
  - flush in REPORT is ignored.
- REPORT:
  - out_valid=1, in_ready=0.
  - Summary outputs are held stable until out_valid && out_ready.
  - On that handshake edge: clear all counters, max_val and sample_count; return to ACCUM; in_ready=1 on the next cycle.
  - Latency: out_valid rises the cycle after the closing sample is accepted. One bubble cycle minimum between windows.
  - out_ready low holds REPORT indefinitely; no samples are lost because in_ready=0 back-pressures the producer.
- Saturation: each counter stops at all-ones. sample_count width is fixed at 8 because WINDOW<=255.
- Reset mid-window or mid-REPORT discards all accumulated data immediately (asynchronous).

Optional Feature:
- Macro: CMP_SELFCHECK_EN.
- Defined: the monitor recomputes a<b, a==b, a>b from the a/b ports. A sample whose l/e/g does not exactly match the recomputed one-hot result is malformed: err_count increments, no category counter changes.
- Not defined: only the one-hot check on l/e/g is applied; a and b are used solely for max_val.

Test Plan:
- Reset, then 16 samples alternating (a=10,b=20,l=1), (a=45,b=45,e=1), with out_ready=1 -> after 16th accept: out_valid=1, lt=8, eq=8, gt=0, err=0, max_val=45, sample_count=16; counters cleared after the handshake.
- 3 samples (a=200,b=7,g=1), then flush=1 -> out_valid next cycle, gt=3, sample_count=3, max_val=200; flush with empty window -> no out_valid.
- Sample with l=1,g=1, then sample with l=e=g=0, then flush -> err_count=2, lt=eq=gt=0, sample_count=2.
- Full window completes, out_ready held 0 for 10 cycles with in_valid=1 -> in_ready=0 and outputs unchanged throughout; out_ready=1 -> ACCUM next cycle, first new sample counted in the new window only.
- rst_n pulsed low mid-window after 5 samples -> outputs zero immediately, without waiting for a clock edge; next window starts from sample_count=0.
- CMP_SELFCHECK_EN defined: a=30,b=40 with g=1 -> err_count=1, gt=0. Same stimulus without the macro -> gt=1, err_count=0.
